fb_write_arbiter: RTL
=====================

// Module: fb_write_arbiter
// PURPOSE
//  Shares the single 64x64 framebuffer write port (write_en/x/y/pixel_color, 12-bit RGB) among NUM_REQ pixel
//  producers (pattern/particle generators, overlays). Uses valid/ready handshakes, round-robin arbitration and
//  paced output slots. Contains a clear sequencer that sweeps the whole frame with CLEAR_COLOR on request.
//  Sits between the producers and the framebuffer/display writer.
// PARAMETERS
//  NUM_REQ      3       number of requesters (2..8)
//  WRITE_DIV    16      clock cycles per write slot (>=2); at most one write issued per slot
//  CLEAR_COLOR  12'h000 colour written by the clear sweep
// PORTS
//  clk          in   1           system clock, all logic on rising edge
//  reset        in   1           asynchronous, active-high reset
//  req_valid    in   NUM_REQ     requester i has a pixel pending
//  req_ready    out  NUM_REQ     grant; transfer when req_valid[i] & req_ready[i]
//  req_x        in   6*NUM_REQ   requester i x at [6*i +: 6]
//  req_y        in   6*NUM_REQ   requester i y at [6*i +: 6]
//  req_color    in   12*NUM_REQ  requester i colour at [12*i +: 12]
//  clear_start  in   1           one-cycle pulse: begin full-frame clear
//  clear_busy   out  1           clear sweep in progress
//  clear_done   out  1           one-cycle pulse with the final clear write
//  write_en     out  1           framebuffer write strobe, one cycle wide
//  write_x      out  6           write column
//  write_y      out  6           write row
//  pixel_color  out  12          write data
// BEHAVIOUR
//  Reset: write_en, write_x, write_y, pixel_color, clear_busy and clear_done go to 0 asynchronously.
//   Reset also sets state=RUN, div_cnt=0, clr_x=clr_y=0 and last_grant=NUM_REQ-1. req_ready is forced 0
//   while reset is high.
//  Slot: div_cnt counts 0..WRITE_DIV-1 and wraps. A cycle with div_cnt==0 is a slot. The first slot is the
//   first clock edge after reset releases.
//  States: RUN and CLEAR.
//   RUN -> CLEAR when clear_start is high. clr_x and clr_y load 0, and clear_busy=1 from the next cycle.
//   CLEAR -> RUN after the write of pixel (63,63) is issued.
//   clear_start while in CLEAR is ignored.
//  RUN slot:
//   req_ready is combinational: one-hot at the first i with req_valid[i], searching
//   last_grant+1, last_grant+2, ... modulo NUM_REQ.
//   Condition: slot & state==RUN & !clear_start & !reset. Outside this condition req_ready is all zero.
//   On a grant, last_grant<=i. Next cycle: write_en=1, and write_x/write_y/pixel_color carry requester i's fields.
//   Latency from accept to write_en is 1 cycle.
//   With no valid request, no write is issued and last_grant is unchanged.
//  CLEAR slot: the next cycle gives write_en=1 at (clr_x,clr_y) with CLEAR_COLOR.
//   The sweep advances x first, 0..63, then increments y. 4096 writes total, no requester grants.
//   On the write of (63,63): clear_done=1 and clear_busy=0 in the same cycle, and state returns to RUN.
//  Non-write cycles: write_en=0. write_x, write_y and pixel_color hold their last values. clear_done=0.
//  clear_start in a RUN slot wins over pending requests: no grant that cycle.
//  Requesters must hold valid and payload stable until accepted. The arbiter samples the payload only on
//   the accept cycle.
//  Reset mid-clear aborts the sweep: no clear_done, state RUN, sweep position discarded.
// TESTING (NUM_REQ=3, WRITE_DIV=4)
//  Reset held, all inputs toggling -> all outputs 0, req_ready=3'b000 throughout.
//  Only req1 valid, (5,7,FF0) held after reset release -> req_ready=3'b010 on the 1st edge.
//   write_en with (5,7,FF0) on the next cycle, then repeats every 4 cycles.
//  req_valid=3'b111 continuously -> grant order 0,1,2,0,1,2, exactly one write_en per 4 cycles.
//   Payloads match the granted requester.
//  clear_start pulse in RUN -> 4096 writes of 000 in raster order (0,0),(1,0)..(63,63), one per 4 cycles.
//   req_ready=0 throughout; clear_done single pulse with (63,63); RUN grants resume at the next slot.
//  clear_start in the same slot as req0 valid -> no grant; first write is clear (0,0).
//   A second clear_start during the sweep has no effect (still 4096 writes, one clear_done).
//  Reset after 100 clear writes -> outputs 0 immediately, clear_busy=0, no clear_done.
//   After release, req2 valid is granted on the first slot.

Source files
------------

// File: rtl/fb_write_arbiter_if.sv
// Producer-side and framebuffer-side signals of the write arbiter.
// The master modport is the driving environment and the slave modport is the arbiter.
interface fb_write_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [6*NUM_REQ-1:0]  req_x;
  logic [6*NUM_REQ-1:0]  req_y;
  logic [12*NUM_REQ-1:0] req_color;
  logic                  clear_start;
  logic                  clear_busy;
  logic                  clear_done;
  logic                  write_en;
  logic [5:0]            write_x;
  logic [5:0]            write_y;
  logic [11:0]           pixel_color;

  modport master (
    output req_valid, req_x, req_y, req_color, clear_start,
    input  req_ready, clear_busy, clear_done, write_en, write_x, write_y, pixel_color
  );

  modport slave (
    input  req_valid, req_x, req_y, req_color, clear_start,
    output req_ready, clear_busy, clear_done, write_en, write_x, write_y, pixel_color
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter sharing the 64x64 framebuffer write port among pixel producers,
// with paced write slots and a full-frame clear sweep.
module fb_write_arbiter #(
  parameter int          NUM_REQ     = 3,
  parameter int          WRITE_DIV   = 16,
  parameter logic [11:0] CLEAR_COLOR = 12'h000
) (
  input  logic              clk,
  input  logic              reset,
  fb_write_arbiter_if.slave bus
);
  localparam int DIV_W = (WRITE_DIV > 1) ? $clog2(WRITE_DIV) : 1;
  localparam int GW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {RUN, CLEAR} state_e;

  typedef struct packed {
    logic [5:0]  x;
    logic [5:0]  y;
    logic [11:0] color;
  } pix_t;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [GW-1:0]     last_q, last_d;
  logic [5:0]        clr_x_q, clr_x_d;
  logic [5:0]        clr_y_q, clr_y_d;
  pix_t              wr_q, wr_d;
  logic              wen_q, wen_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  pix_t [NUM_REQ-1:0] req_pix;
  logic [NUM_REQ-1:0] gnt;
  logic [GW-1:0]      gnt_idx;
  logic               gnt_any;
  logic               slot;
  logic               arb_en;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign req_pix[i] = {bus.req_x[6*i +: 6], bus.req_y[6*i +: 6], bus.req_color[12*i +: 12]};
  end

  assign slot   = (div_q == '0);
  assign arb_en = slot && (state_q == RUN) && !bus.clear_start && !reset;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = last_q;
    gnt_any = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!gnt_any && bus.req_valid[idx]) begin
        gnt_any  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = GW'(idx);
      end
    end
  end

  assign bus.req_ready = arb_en ? gnt : '0;

  always_comb begin
    state_d = state_q;
    div_d   = (div_q == DIV_W'(WRITE_DIV - 1)) ? '0 : div_q + DIV_W'(1);
    last_d  = last_q;
    clr_x_d = clr_x_q;
    clr_y_d = clr_y_q;
    wr_d    = wr_q;
    wen_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.clear_start) begin
          state_d = CLEAR;
          clr_x_d = '0;
          clr_y_d = '0;
          busy_d  = 1'b1;
        end else if (arb_en && gnt_any) begin
          last_d = gnt_idx;
          wen_d  = 1'b1;
          wr_d   = req_pix[gnt_idx];
        end
      end
      CLEAR: begin
        if (slot) begin
          wen_d   = 1'b1;
          wr_d    = '{x: clr_x_q, y: clr_y_q, color: CLEAR_COLOR};
          clr_x_d = clr_x_q + 6'd1;
          if (clr_x_q == 6'd63) begin
            clr_y_d = clr_y_q + 6'd1;
            // Last pixel of the frame: leave CLEAR together with the final write.
            if (clr_y_q == 6'd63) begin
              state_d = RUN;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      div_q   <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      clr_x_q <= '0;
      clr_y_q <= '0;
      wr_q    <= '0;
      wen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      last_q  <= last_d;
      clr_x_q <= clr_x_d;
      clr_y_q <= clr_y_d;
      wr_q    <= wr_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.write_en    = wen_q;
  assign bus.write_x     = wr_q.x;
  assign bus.write_y     = wr_q.y;
  assign bus.pixel_color = wr_q.color;
  assign bus.clear_busy  = busy_q;
  assign bus.clear_done  = done_q;
endmodule
